// File: rtl/chacha20_top.sv
// ChaCha20 block function core.
// Builds the 16-word state from key/counter/nonce, runs ROUNDS rounds one per
// clock (alternating column and diagonal rounds), then adds the saved initial
// state and presents the serialized 512-bit keystream block with a level done.
module chacha20_top #(
  parameter int ROUNDS = 20
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [255:0] key,
  input  logic [31:0]  counter,
  input  logic [95:0]  nonce,
  output logic [511:0] keystream,
  output logic         done
);

  localparam int RW = $clog2(ROUNDS + 1);
  localparam logic [RW-1:0] LAST_ROUND = RW'(ROUNDS);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ROUND = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]    r_state;
  logic [RW-1:0] r_round;
  logic [31:0]   r_work [16];
  logic [31:0]   r_init [16];
  logic [511:0]  r_keystream;
  logic          r_done;

  logic [31:0]   w_load  [16];
  logic [31:0]   w_round [16];
  logic [31:0]   w_qin   [4][4];
  logic [31:0]   w_qout  [4][4];
  logic [511:0]  w_final;
  logic          w_is_col;

  function automatic logic [31:0] bswap32(input logic [31:0] v);
    return {v[7:0], v[15:8], v[23:16], v[31:24]};
  endfunction

  function automatic logic [127:0] quarter_round(input logic [31:0] a_in,
                                                 input logic [31:0] b_in,
                                                 input logic [31:0] c_in,
                                                 input logic [31:0] d_in);
    logic [31:0] a, b, c, d;
    a = a_in; b = b_in; c = c_in; d = d_in;
    a = a + b; d = d ^ a; d = {d[15:0], d[31:16]};
    c = c + d; b = b ^ c; b = {b[19:0], b[31:20]};
    a = a + b; d = d ^ a; d = {d[23:0], d[31:24]};
    c = c + d; b = b ^ c; b = {b[24:0], b[31:25]};
    return {a, b, c, d};
  endfunction

  // Round counter is even before an odd-numbered (column) round.
  assign w_is_col = ~r_round[0];

  genvar gi, gj;

  // Initial state: constants, LE key words, counter, LE nonce words.
  generate
    for (gi = 0; gi < 16; gi++) begin : g_load
      if (gi == 0) begin : g_c0
        assign w_load[gi] = 32'h61707865;
      end else if (gi == 1) begin : g_c1
        assign w_load[gi] = 32'h3320646e;
      end else if (gi == 2) begin : g_c2
        assign w_load[gi] = 32'h79622d32;
      end else if (gi == 3) begin : g_c3
        assign w_load[gi] = 32'h6b206574;
      end else if (gi < 12) begin : g_key
        assign w_load[gi] = bswap32(key[255-32*(gi-4) -: 32]);
      end else if (gi == 12) begin : g_ctr
        assign w_load[gi] = counter;
      end else begin : g_nonce
        assign w_load[gi] = bswap32(nonce[95-32*(gi-13) -: 32]);
      end
    end
  endgenerate

  // Four shared quarter-round units; the diagonal round is a rotation of
  // row gj by gj positions, so only the input/output routing changes.
  generate
    for (gi = 0; gi < 4; gi++) begin : g_qr
      for (gj = 0; gj < 4; gj++) begin : g_qin
        assign w_qin[gi][gj] = w_is_col ? r_work[4*gj + gi]
                                        : r_work[4*gj + ((gi + gj) % 4)];
      end
      assign {w_qout[gi][0], w_qout[gi][1], w_qout[gi][2], w_qout[gi][3]} =
        quarter_round(w_qin[gi][0], w_qin[gi][1], w_qin[gi][2], w_qin[gi][3]);
    end
  endgenerate

  // Route quarter-round results back to their state word positions.
  generate
    for (gi = 0; gi < 16; gi++) begin : g_wb
      assign w_round[gi] = w_is_col ? w_qout[gi % 4][gi / 4]
                                    : w_qout[((gi % 4) - (gi / 4) + 4) % 4][gi / 4];
      assign w_final[511-32*gi -: 32] = bswap32(r_work[gi] + r_init[gi]);
    end
  endgenerate

  // FSM: capture on start, iterate rounds, then publish the keystream block.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_round     <= '0;
      r_keystream <= '0;
      r_done      <= 1'b0;
      for (int i = 0; i < 16; i++) begin
        r_work[i] <= '0;
        r_init[i] <= '0;
      end
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            for (int i = 0; i < 16; i++) begin
              r_work[i] <= w_load[i];
              r_init[i] <= w_load[i];
            end
            r_round <= '0;
            r_done  <= 1'b0;
            r_state <= S_ROUND;
          end
        end
        S_ROUND: begin
          if (r_round == LAST_ROUND) begin
            r_keystream <= w_final;
            r_done      <= 1'b1;
            r_state     <= S_DONE;
          end else begin
            for (int i = 0; i < 16; i++) begin
              r_work[i] <= w_round[i];
            end
            r_round <= r_round + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign keystream = r_keystream;
  assign done      = r_done;

endmodule

// File: tb/tb_chacha20_top.sv
// Scoreboard bench for chacha20_top: stimulus pushes expected blocks and their
// completion cycle; a monitor pops and compares on each rising done.
module tb_chacha20_top;

  localparam logic [255:0] KEY_RFC   = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [95:0]  NONCE_RFC = 96'h000000090000004a00000000;
  localparam logic [511:0] KS_RFC    = 512'h10f1e7e4d13b5915500fdd1fa32071c4c7d1f4c733c068030422aa9ac3d46c4ed2826446079faa0914c2d705d98b02a2b5129cd1de164eb9cbd083e8a2503c4e;
  localparam logic [511:0] KS_ZERO   = 512'h76b8e0ada0f13d90405d6ae55386bd28bdd219b8a08ded1aa836efcc8b770dc7da41597c5157488d7724e03fb8d84a376a43b8f41518a11cc387b669b2ee6586;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic [255:0] key = '0;
  logic [31:0]  counter = '0;
  logic [95:0]  nonce = '0;
  logic [511:0] keystream;
  logic         done;

  always #5 clk = ~clk;

  chacha20_top #(.ROUNDS(20)) dut (
    .clk(clk), .reset(reset), .start(start), .key(key), .counter(counter),
    .nonce(nonce), .keystream(keystream), .done(done)
  );

  typedef struct {
    logic [511:0] ks;
    int           cyc;
    string        nm;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  logic prev_done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] rotl(input logic [31:0] v, input int n);
    return (v << n) | (v >> (32 - n));
  endfunction

  // Reference block function: byte-level state build, 10 double rounds.
  function automatic logic [511:0] ref_block(input logic [255:0] k, input logic [31:0] c,
                                             input logic [95:0] n);
    logic [31:0]  s[16];
    logic [31:0]  x[16];
    logic [31:0]  a, b, cc, d, v;
    logic [511:0] res;
    int qt[8][4];
    qt = '{'{0,4,8,12}, '{1,5,9,13}, '{2,6,10,14}, '{3,7,11,15},
           '{0,5,10,15}, '{1,6,11,12}, '{2,7,8,13}, '{3,4,9,14}};
    s[0] = 32'h61707865; s[1] = 32'h3320646e; s[2] = 32'h79622d32; s[3] = 32'h6b206574;
    for (int i = 0; i < 8; i++)
      for (int bb = 0; bb < 4; bb++)
        s[4+i][8*bb +: 8] = k[255-8*(4*i+bb) -: 8];
    s[12] = c;
    for (int i = 0; i < 3; i++)
      for (int bb = 0; bb < 4; bb++)
        s[13+i][8*bb +: 8] = n[95-8*(4*i+bb) -: 8];
    x = s;
    for (int r = 0; r < 10; r++) begin
      for (int q = 0; q < 8; q++) begin
        a = x[qt[q][0]]; b = x[qt[q][1]]; cc = x[qt[q][2]]; d = x[qt[q][3]];
        a = a + b;  d = rotl(d ^ a, 16);
        cc = cc + d; b = rotl(b ^ cc, 12);
        a = a + b;  d = rotl(d ^ a, 8);
        cc = cc + d; b = rotl(b ^ cc, 7);
        x[qt[q][0]] = a; x[qt[q][1]] = b; x[qt[q][2]] = cc; x[qt[q][3]] = d;
      end
    end
    res = '0;
    for (int w = 0; w < 16; w++) begin
      v = x[w] + s[w];
      for (int bb = 0; bb < 4; bb++)
        res[511-8*(4*w+bb) -: 8] = v[8*bb +: 8];
    end
    return res;
  endfunction

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Monitor: every rising done must match the oldest pending expectation.
  always @(negedge clk) begin
    exp_t e;
    if (reset && done && !prev_done) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_done at cycle %0d: got done=1 want no result", cyc);
      end else begin
        e = sb.pop_front();
        chk({e.nm, "_keystream"}, keystream, e.ks);
        checks++;
        if (cyc != e.cyc) begin
          errors++;
          $display("FAIL %s_latency: got cycle %0d want cycle %0d", e.nm, cyc, e.cyc);
        end
        $display("txn %s cycle %0d keystream %h", e.nm, cyc, keystream);
      end
    end
    prev_done = done;
  end

  task automatic issue(input logic [255:0] k, input logic [31:0] c, input logic [95:0] n,
                       input logic [511:0] exp, input string nm);
    @(negedge clk);
    key = k; counter = c; nonce = n; start = 1'b1;
    sb.push_back('{ks: exp, cyc: cyc + 1 + 21, nm: nm});
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_empty(input string nm);
    int t = 0;
    while (sb.size() != 0 && t < 40) begin
      @(negedge clk); #1;
      t++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s_timeout: got %0d pending want 0", nm, sb.size());
      sb.delete();
    end
  endtask

  initial begin
    int bad;
    logic [511:0] held;
    logic [255:0] rk;
    logic [31:0]  rc;
    logic [95:0]  rn;

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset_done", done, 0);
    chk("reset_keystream", keystream, 0);
    reset = 1'b1;

    // Idle hold
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (done !== 1'b0 || keystream !== '0) bad++;
    end
    chk("idle_hold", bad, 0);

    // RFC vector, with inputs changed and a busy start during ROUND
    issue(KEY_RFC, 32'd1, NONCE_RFC, KS_RFC, "rfc");
    key = ~KEY_RFC; counter = 32'h55; nonce = ~NONCE_RFC;
    repeat (4) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_empty("rfc");

    // Result held in DONE
    held = keystream;
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (done !== 1'b1 || keystream !== held) bad++;
    end
    chk("done_hold", bad, 0);

    // Back-to-back zero vector
    issue('0, 32'd0, '0, KS_ZERO, "zero");
    chk("b2b_done_fall", done, 0);
    chk("b2b_keystream_kept", keystream, KS_RFC);
    wait_empty("zero");

    // Reset mid-operation
    rk = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    issue(rk, 32'd7, 96'h1, ref_block(rk, 32'd7, 96'h1), "abort");
    repeat (9) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("abort_done", done, 0);
    chk("abort_keystream", keystream, 0);
    sb.delete();
    @(negedge clk);
    reset = 1'b1;
    issue(KEY_RFC, 32'd1, NONCE_RFC, KS_RFC, "rfc_after_reset");
    wait_empty("rfc_after_reset");

    // Random vectors against the reference model
    for (int i = 0; i < 8; i++) begin
      rk = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      rc = $urandom();
      rn = {$urandom(), $urandom(), $urandom()};
      if (i == 0) rc = 32'hffffffff;
      if (i == 1) rk = '1;
      issue(rk, rc, rn, ref_block(rk, rc, rn), $sformatf("rand%0d", i));
      wait_empty($sformatf("rand%0d", i));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    chk("scoreboard_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/chacha20_top.md
Name: chacha20_top

Overview:
ChaCha20 block function core per RFC 8439 §2.3. It takes a 256-bit key, a 32-bit block counter and a 96-bit nonce, and produces one 512-bit keystream block. It is iterative, with one round (4 quarter-rounds in parallel) per clock. It sits under the stream-cipher datapath, which XORs the keystream with data and advances the counter.

Parameters:
ROUNDS  20  number of ChaCha rounds; must be even and >=2 (odd round = column, even round = diagonal)

Ports:
clk        input   1    rising-edge clock
reset      input   1    asynchronous, active-low reset (0 = reset asserted)
start      input   1    request a block; sampled on rising clk
key        input   256  key; key[255:248] = key byte 0
counter    input   32   block counter; used directly as state word 12
nonce      input   96   nonce; nonce[95:88] = nonce byte 0
keystream  output  512  serialized keystream; keystream[511:504] = output byte 0
done       output  1    block ready; level signal, held until next accepted start

Behaviour:
- One clock domain. Reset is asynchronous and active-low. The reset name follows the codebase (reset); its polarity and synchronicity are fixed.
- In reset:
  - FSM goes to IDLE.
  - keystream = 0 and done = 0.
  - Working state, saved initial state and round counter are cleared.
- State words, 32-bit, little-endian from bytes:
  - w0..w3 = 61707865, 3320646e, 79622d32, 6b206574.
  - w4..w11 = key bytes 4i..4i+3 packed LE (key byte 0 -> w4 = 0x03020100 for key 00..1f).
  - w12 = counter.
  - w13..w15 = nonce bytes packed LE (nonce 000000090000004a00000000 -> w13 = 09000000, w14 = 4a000000, w15 = 0).
- Quarter-round QR(a,b,c,d), all adds mod 2^32:
  - a+=b; d^=a; d<<<=16
  - c+=d; b^=c; b<<<=12
  - a+=b; d^=a; d<<<=8
  - c+=d; b^=c; b<<<=7
- Column round: QR(0,4,8,12), QR(1,5,9,13), QR(2,6,10,14), QR(3,7,11,15).
- Diagonal round: QR(0,5,10,15), QR(1,6,11,12), QR(2,7,8,13), QR(3,4,9,14).
- FSM states: IDLE, ROUND, DONE.
  - E0, start=1 sampled in IDLE or DONE: key/counter/nonce are captured into the initial state and working state. Round counter = 0, done <= 0, go to ROUND. Inputs may change after E0 without effect.
  - E1..E_ROUNDS: one round per edge. Odd-numbered rounds are column rounds, even-numbered rounds are diagonal rounds.
  - E_(ROUNDS+1): keystream <= working + initial (per word, mod 2^32), serialized LE. done <= 1, go to DONE.
  - done therefore rises 21 edges after the start-sampling edge at ROUNDS=20.
- DONE: keystream and done are held stable until a new start is accepted. Accepting start clears done in the same edge; keystream keeps its old value until the next result is written.
- start while in ROUND is ignored; no restart, no queuing.
- A start held high continuously in DONE restarts every time the FSM returns to DONE. The producer must pulse start.
- Reset asserted mid-operation aborts immediately. After release the FSM is in IDLE with done = 0 and keystream = 0.
- Counter wrap is the caller's responsibility; the block does no counter increment.

Test Plan:
- RFC 8439 §2.3.2 vector:
  - Stimulus: key=000102..1e1f, nonce=000000090000004a00000000, counter=1, start pulse.
  - Required: done after 21 edges; keystream = 10f1e7e4d13b5915500fdd1fa32071c4c7d1f4c733c068030422aa9ac3d46c4ed2826446079faa0914c2d705d98b02a2b5129cd1de164eb9cbd083e8a2503c4e.
- All-zero vector:
  - Stimulus: key=0, nonce=0, counter=0, start pulse.
  - Required: keystream = 76b8e0ada0f13d90405d6ae55386bd28bdd219b8a08ded1aa836efcc8b770dc7da41597c5157488d7724e03fb8d84a376a43b8f41518a11cc387b669b2ee6586.
- Input capture and busy-start:
  - Stimulus: start the §2.3.2 vector, then change key/counter and pulse start during ROUND.
  - Required: result is still the §2.3.2 keystream at the same cycle; the second start has no effect.
- Back-to-back:
  - Stimulus: after done, pulse start with the zero vector.
  - Required: done falls on the accepting edge, rises 21 edges later with the zero-vector keystream.
- Reset mid-operation:
  - Stimulus: assert reset (0) 10 cycles after start, asynchronously between edges.
  - Required: done = 0 and keystream = 0 immediately. After release, a fresh start produces the correct keystream.
- Idle hold:
  - Stimulus: no start for 100 cycles after reset.
  - Required: done stays 0 and keystream stays 0.
